// File: rtl/decimal_event_counter.sv
// Debounced push-button up/down/clear counter for a 4-digit display.
// Optional down-counting on btn_dec is enabled by defining DECIMAL_EVENT_COUNTER_DOWN_EN.
module decimal_event_counter #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_COUNT       = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        btn_clr,
    output logic [15:0] displayed_number,
    output logic        wrap
);

`ifdef DECIMAL_EVENT_COUNTER_DOWN_EN
    localparam int unsigned NB = 3;
`else
    localparam int unsigned NB = 2;
`endif
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0]   MAX_VAL = 16'(MAX_COUNT);

    // Lane order: [0] inc, [1] clr, [2] dec (only when down-counting is built in)
    logic [NB-1:0] w_raw;
    logic [NB-1:0] r_sync1;
    logic [NB-1:0] r_sync2;
    logic [NB-1:0] r_db;
    logic [NB-1:0] r_db_prev;
    logic [NB-1:0] r_press;
    logic [CW-1:0] r_cnt [NB];
    logic          w_inc;
    logic          w_clr;
    logic          w_dec;
    logic [15:0]   r_count;
    logic          r_wrap;

`ifdef DECIMAL_EVENT_COUNTER_DOWN_EN
    assign w_raw = {btn_dec, btn_clr, btn_inc};
    assign w_dec = r_press[2];
`else
    logic w_unused_dec;
    assign w_raw        = {btn_clr, btn_inc};
    assign w_dec        = 1'b0;
    assign w_unused_dec = btn_dec;
`endif
    assign w_inc = r_press[0];
    assign w_clr = r_press[1];

    // The debounce counter only runs while the synchronized level disagrees with
    // the accepted level; any return to agreement restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_db      <= '0;
            r_db_prev <= '0;
            r_press   <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1   <= w_raw;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db;
            r_press   <= r_db & ~r_db_prev;
            for (int unsigned i = 0; i < NB; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_LAST) begin
                    r_db[i]  <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_clr) begin
                r_count <= '0;
            end else if (w_inc && !w_dec) begin
                if (r_count >= MAX_VAL) begin
                    r_count <= '0;
                    r_wrap  <= 1'b1;
                end else begin
                    r_count <= r_count + 16'd1;
                end
            end else if (w_dec && !w_inc) begin
                if (r_count == '0) begin
                    r_count <= MAX_VAL;
                    r_wrap  <= 1'b1;
                end else if (r_count > MAX_VAL) begin
                    r_count <= MAX_VAL;
                end else begin
                    r_count <= r_count - 16'd1;
                end
            end
        end
    end

    assign displayed_number = r_count;
    assign wrap             = r_wrap;

endmodule
